fetch_realign_fifo: RTL and testbench
=====================================

Name: fetch_realign_fifo

Overview:
- Parametrised halfword-granular instruction queue between the instruction-fetch port and decode.
- Accepts aligned 32-bit fetch words and presents 16/32-bit RISC-V instructions realigned to any halfword boundary.
- Tracks the instruction PC internally, so no per-entry address storage is needed.
- Successor to the fixed 4-entry realign buffer: adds configurable depth, a valid/ready handshake on both sides, explicit compressed detection, and a redirect that can start on an odd halfword.

Parameters:
- DEPTH, 4, capacity in 32-bit words; power of two, >= 2; storage is 2*DEPTH halfwords.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- clear_i  input  1  synchronous flush/redirect
- clear_addr_i  input  ADDR_WIDTH  redirect PC; bit 0 ignored
- fetch_valid_i  input  1  fetch word valid
- fetch_ready_o  output  1  buffer can accept a word
- fetch_data_i  input  32  aligned fetch word; halfword 0 = bits [15:0]
- instr_valid_o  output  1  complete instruction at head
- instr_ready_i  input  1  decode consumes head instruction
- instr_o  output  32  head instruction; upper 16 bits are don't-care when compressed
- instr_compressed_o  output  1  head instruction is 16-bit (instr_o[1:0] != 2'b11)
- instr_addr_o  output  ADDR_WIDTH  PC of head instruction
- count_o  output  $clog2(2*DEPTH)+1  stored halfword count

Behaviour:
- Reset (rst_n low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, pc=0, skip_hw=0, all valid flags cleared.
  - Outputs: instr_valid_o=0, fetch_ready_o=1, instr_addr_o=0, count_o=0.
- Storage: circular array of 2*DEPTH halfwords.
  - rd_ptr and wr_ptr are halfword indices that wrap modulo 2*DEPTH.
  - A head instruction may straddle the wrap point (index 2*DEPTH-1 followed by 0) and must be assembled correctly.
- Push:
  - Accepted when fetch_valid_i && fetch_ready_o.
  - fetch_ready_o = (2*DEPTH - count) >= 2, computed from registered count only (no combinational path from instr_ready_i).
  - A push writes both halfwords and advances wr_ptr by 2.
  - Exception: when skip_hw=1, only bits [31:16] are written, wr_ptr advances by 1, and skip_hw clears.
- Head decode:
  - h0 = mem[rd_ptr], h1 = mem[rd_ptr+1].
  - Compressed when h0[1:0] != 2'b11.
  - instr_valid_o = (count >= 1 && compressed) || count >= 2.
  - instr_o = {h1, h0}.
- Pop:
  - Occurs when instr_valid_o && instr_ready_i.
  - Advances rd_ptr and decrements count by 1 (compressed) or 2 (32-bit).
  - pc advances by 2 or 4 respectively; instr_addr_o = pc.
- Simultaneous push and pop: count_next = count + push_hw - pop_hw. Both are legal in the same cycle, including at full and at empty.
- Clear:
  - Highest priority; any push or pop in the same cycle is discarded.
  - Next cycle: count=0, rd_ptr=wr_ptr=0, pc = {clear_addr_i[ADDR_WIDTH-1:1], 1'b0}, skip_hw = clear_addr_i[1].
- Fault condition: instr_ready_i while !instr_valid_o is ignored.
- Reset mid-operation: all state is lost immediately; no partial instruction is retained.

Optional Feature:
- FETCH_REALIGN_BYPASS_EN defined: the head window is drawn from stored halfwords followed by the halfwords of the incoming fetch word in the current cycle (after skip_hw handling).
  - instr_valid_o, instr_o and instr_compressed_o are computed over this combined view, giving 0-cycle latency when the buffer is empty.
  - Bypassed halfwords that are consumed in the same cycle are not stored; any remainder is stored.
  - count update is unchanged.
- Macro undefined: the head window uses stored halfwords only; minimum latency from fetch to instr_valid_o is 1 cycle.

Decomposition:
- Shared package riscv_defines: RISCV_WORD_WIDTH, RISCV_HALF_WIDTH=16, and an is_compressed(h) function also used by the decoder.
- Optional sub-module realign_head_mux: combinational assembly of {h1,h0} from the storage array plus optional bypass, and length decode. Keeps the wrap-around and bypass muxing out of the pointer logic.

Test Plan:
- Clear with clear_addr_i=0x100, then push 0x00130093 and 0x00000013 -> two 32-bit instructions at PCs 0x100 and 0x104; instr_compressed_o=0; count returns to 0.
- Clear with clear_addr_i=0x102, push 0x4505_0001 -> only 0x4505 stored (count=1); head is a compressed instruction at 0x102.
- Push 0x0093_4501 then 0x0000_0013 -> compressed 0x4501 @0x0, then 32-bit 0x00130093 @0x2 straddling two words, then 0x0000 @0x6 (compressed).
- DEPTH=4: push 4 words with instr_ready_i=0 -> fetch_ready_o=0, count=8. Hold fetch_valid_i and pop one 32-bit instruction -> same-cycle push/pop legal; count stays 8 after refill. Run 3 wraps with a straddling instruction at index 7->0 -> instr_o correct.
- Assert clear_i together with fetch_valid_i and instr_ready_i -> no push, no pop; next cycle count=0, instr_valid_o=0.
- Assert rst_n low mid-stream -> outputs reach their reset values asynchronously. With FETCH_REALIGN_BYPASS_EN and an empty buffer, push 0x00000013 with instr_ready_i=1 -> instr_valid_o=1 in the same cycle; count stays 0.

Source files
------------

// File: rtl/fetch_realign_fifo_pkg.sv
// Shared RISC-V width constants and the compressed-instruction test.
// Decode uses the same is_compressed() helper.
package riscv_defines;

    localparam int RISCV_WORD_WIDTH = 32;
    localparam int RISCV_HALF_WIDTH = 16;

    // A halfword starts a 16-bit instruction unless its low two bits are 2'b11.
    function automatic logic is_compressed(input logic [RISCV_HALF_WIDTH-1:0] h);
        return h[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_realign_fifo_head_mux.sv
// realign_head_mux: builds the head instruction window {h1,h0} and its length.
// With FETCH_REALIGN_BYPASS_EN the incoming fetch halfwords extend the stored ones.
module realign_head_mux
    import riscv_defines::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(2*DEPTH),
    parameter int CNT_W = PTR_W + 1
) (
    input  logic [RISCV_HALF_WIDTH-1:0] mem [2*DEPTH],
    input  logic [PTR_W-1:0]            rd_ptr,
    input  logic [CNT_W-1:0]            count,
`ifdef FETCH_REALIGN_BYPASS_EN
    input  logic                        bypass_valid,
    input  logic                        skip_hw,
    input  logic [RISCV_WORD_WIDTH-1:0] bypass_data,
`endif
    output logic [RISCV_WORD_WIDTH-1:0] instr,
    output logic                        compressed,
    output logic                        valid
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0]            rd_ptr_next;
    logic [RISCV_HALF_WIDTH-1:0] h0;
    logic [RISCV_HALF_WIDTH-1:0] h1;
    logic [CNT_W:0]              avail;

    // Pointer arithmetic is modulo 2*DEPTH, so a straddling head wraps 2*DEPTH-1 -> 0.
    assign rd_ptr_next = rd_ptr + PTR_ONE;

`ifdef FETCH_REALIGN_BYPASS_EN
    logic [RISCV_HALF_WIDTH-1:0] in0;
    logic [RISCV_HALF_WIDTH-1:0] in1;
    logic [CNT_W:0]              n_in;

    always_comb begin
        in0  = skip_hw ? bypass_data[31:16] : bypass_data[15:0];
        in1  = bypass_data[31:16];
        n_in = !bypass_valid ? '0 : (skip_hw ? (CNT_W+1)'(1) : (CNT_W+1)'(2));
        h0   = mem[rd_ptr];
        h1   = mem[rd_ptr_next];
        if (count == '0) begin
            h0 = in0;
            h1 = in1;
        end else if (count == CNT_W'(1)) begin
            h1 = in0;
        end
        avail = {1'b0, count} + n_in;
    end
`else
    always_comb begin
        h0    = mem[rd_ptr];
        h1    = mem[rd_ptr_next];
        avail = {1'b0, count};
    end
`endif

    always_comb begin
        instr      = {h1, h0};
        compressed = is_compressed(h0);
        valid      = (avail >= (CNT_W+1)'(1) && compressed) || avail >= (CNT_W+1)'(2);
    end

endmodule

// File: rtl/fetch_realign_fifo.sv
// Halfword-granular fetch queue presenting realigned 16/32-bit RISC-V instructions.
// Optional build macro FETCH_REALIGN_BYPASS_EN enables 0-cycle fetch-to-decode bypass.
module fetch_realign_fifo
    import riscv_defines::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_i,
    input  logic [ADDR_WIDTH-1:0]         clear_addr_i,
    input  logic                          fetch_valid_i,
    output logic                          fetch_ready_o,
    input  logic [RISCV_WORD_WIDTH-1:0]   fetch_data_i,
    output logic                          instr_valid_o,
    input  logic                          instr_ready_i,
    output logic [RISCV_WORD_WIDTH-1:0]   instr_o,
    output logic                          instr_compressed_o,
    output logic [ADDR_WIDTH-1:0]         instr_addr_o,
    output logic [$clog2(2*DEPTH):0]      count_o
);

    localparam int HW_DEPTH = 2 * DEPTH;
    localparam int PTR_W    = $clog2(HW_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    // NOTE: storage has no reset; count and pointers alone decide what is valid.
    logic [RISCV_HALF_WIDTH-1:0] mem [HW_DEPTH];

    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  skip_hw;

    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      push_add;
    logic [CNT_W-1:0]      pop_sub;

    assign fetch_ready_o = count <= CNT_W'(HW_DEPTH - 2);
    assign push          = fetch_valid_i && fetch_ready_o && !clear_i;
    assign pop           = instr_valid_o && instr_ready_i && !clear_i;
    assign push_add      = !push ? '0 : (skip_hw ? CNT_W'(1) : CNT_W'(2));
    assign pop_sub       = !pop ? '0 : (instr_compressed_o ? CNT_W'(1) : CNT_W'(2));
    assign count_o       = count;
    assign instr_addr_o  = pc;

    realign_head_mux #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .CNT_W (CNT_W)
    ) u_head_mux (
        .mem          (mem),
        .rd_ptr       (rd_ptr),
        .count        (count),
`ifdef FETCH_REALIGN_BYPASS_EN
        .bypass_valid (fetch_valid_i && fetch_ready_o),
        .skip_hw      (skip_hw),
        .bypass_data  (fetch_data_i),
`endif
        .instr        (instr_o),
        .compressed   (instr_compressed_o),
        .valid        (instr_valid_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pc      <= '0;
            skip_hw <= 1'b0;
        end else if (clear_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            pc      <= clear_addr_i & ~ADDR_WIDTH'(1);
            skip_hw <= clear_addr_i[1];
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + (skip_hw ? PTR_W'(1) : PTR_W'(2));
                skip_hw <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (instr_compressed_o ? PTR_W'(1) : PTR_W'(2));
                pc     <= pc + (instr_compressed_o ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
            end
            count <= count + push_add - pop_sub;
        end
    end

    // Every accepted word is written; bypassed halfwords popped in the same
    // cycle land in slots rd_ptr skips over, so they are released at once.
    always_ff @(posedge clk) begin
        if (push) begin
            if (skip_hw) begin
                mem[wr_ptr] <= fetch_data_i[31:16];
            end else begin
                mem[wr_ptr]                <= fetch_data_i[15:0];
                mem[wr_ptr + PTR_W'(1)]    <= fetch_data_i[31:16];
            end
        end
    end

endmodule

// File: tb/tb_fetch_realign_fifo.sv
// Directed self-checking bench for fetch_realign_fifo (DEPTH=4).
// Covers both builds; the bypass check depends on FETCH_REALIGN_BYPASS_EN.
module tb_fetch_realign_fifo;

    localparam int DEPTH      = 4;
    localparam int ADDR_WIDTH = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clear_i;
    logic [ADDR_WIDTH-1:0]   clear_addr_i;
    logic                    fetch_valid_i;
    logic                    fetch_ready_o;
    logic [31:0]             fetch_data_i;
    logic                    instr_valid_o;
    logic                    instr_ready_i;
    logic [31:0]             instr_o;
    logic                    instr_compressed_o;
    logic [ADDR_WIDTH-1:0]   instr_addr_o;
    logic [$clog2(2*DEPTH):0] count_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] stream_w  [13];
    logic [31:0] exp_instr [16];
    logic [31:0] exp_pc    [16];
    logic        exp_c     [16];

    fetch_realign_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clear_i            (clear_i),
        .clear_addr_i       (clear_addr_i),
        .fetch_valid_i      (fetch_valid_i),
        .fetch_ready_o      (fetch_ready_o),
        .fetch_data_i       (fetch_data_i),
        .instr_valid_o      (instr_valid_o),
        .instr_ready_i      (instr_ready_i),
        .instr_o            (instr_o),
        .instr_compressed_o (instr_compressed_o),
        .instr_addr_o       (instr_addr_o),
        .count_o            (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic [31:0] addr);
        clear_i      = 1'b1;
        clear_addr_i = addr;
        step();
        clear_i      = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        fetch_valid_i = 1'b1;
        fetch_data_i  = w;
        step();
        fetch_valid_i = 1'b0;
    endtask

    task automatic pop_one();
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
    endtask

    initial begin
        int  wi;
        int  ii;
        logic push_ok;
        logic pop_ok;

        rst_n = 1'b0; clear_i = 1'b0; clear_addr_i = '0;
        fetch_valid_i = 1'b0; fetch_data_i = '0; instr_ready_i = 1'b0;

        // Wrap stream: skip-start compressed 0x0001, then laps whose last
        // 32-bit instruction straddles halfword index 7 -> 0.
        stream_w[0] = 32'h0001_FFFF;
        for (int l = 0; l < 3; l++) begin
            stream_w[1 + 4*l] = 32'h0093_4505;
            stream_w[2 + 4*l] = 32'h4509_0013;
            stream_w[3 + 4*l] = 32'h0020_0113;
            stream_w[4 + 4*l] = 32'h0030_0193;
        end
        exp_instr[0] = 32'h0000_0001; exp_pc[0] = 32'h2; exp_c[0] = 1'b1;
        for (int l = 0; l < 3; l++) begin
            exp_instr[1 + 5*l] = 32'h0000_4505; exp_pc[1 + 5*l] = 32'h04 + 32'h10*l; exp_c[1 + 5*l] = 1'b1;
            exp_instr[2 + 5*l] = 32'h0013_0093; exp_pc[2 + 5*l] = 32'h06 + 32'h10*l; exp_c[2 + 5*l] = 1'b0;
            exp_instr[3 + 5*l] = 32'h0000_4509; exp_pc[3 + 5*l] = 32'h0A + 32'h10*l; exp_c[3 + 5*l] = 1'b1;
            exp_instr[4 + 5*l] = 32'h0020_0113; exp_pc[4 + 5*l] = 32'h0C + 32'h10*l; exp_c[4 + 5*l] = 1'b0;
            exp_instr[5 + 5*l] = 32'h0030_0193; exp_pc[5 + 5*l] = 32'h10 + 32'h10*l; exp_c[5 + 5*l] = 1'b0;
        end

        #2;
        check("rst_valid", instr_valid_o, 1'b0);
        check("rst_ready", fetch_ready_o, 1'b1);
        check("rst_addr",  instr_addr_o, 32'h0);
        check("rst_count", count_o, 0);
        #10 rst_n = 1'b1;
        step();

        // Two aligned 32-bit instructions
        do_clear(32'h100);
        check("clr_addr", instr_addr_o, 32'h100);
        push_word(32'h0013_0093);
        push_word(32'h0000_0013);
        check("a_count", count_o, 4);
        check("a_instr0", instr_o, 32'h0013_0093);
        check("a_c0", instr_compressed_o, 1'b0);
        check("a_pc0", instr_addr_o, 32'h100);
        pop_one();
        check("a_instr1", instr_o, 32'h0000_0013);
        check("a_pc1", instr_addr_o, 32'h104);
        pop_one();
        check("a_count_end", count_o, 0);
        check("a_valid_end", instr_valid_o, 1'b0);

        // Redirect to an odd halfword: only the upper half is stored
        do_clear(32'h102);
        push_word(32'h4505_0001);
        check("b_count", count_o, 1);
        check("b_valid", instr_valid_o, 1'b1);
        check("b_c", instr_compressed_o, 1'b1);
        check("b_instr", {16'h0, instr_o[15:0]}, 32'h4505);
        check("b_pc", instr_addr_o, 32'h102);
        pop_one();
        check("b_count_end", count_o, 0);
        check("b_pc_end", instr_addr_o, 32'h104);

        // Mixed lengths with a 32-bit instruction straddling two words
        do_clear(32'h0);
        push_word(32'h0093_4501);
        push_word(32'h0000_0013);
        check("c_instr0", {16'h0, instr_o[15:0]}, 32'h4501);
        check("c_c0", instr_compressed_o, 1'b1);
        check("c_pc0", instr_addr_o, 32'h0);
        pop_one();
        check("c_instr1", instr_o, 32'h0013_0093);
        check("c_c1", instr_compressed_o, 1'b0);
        check("c_pc1", instr_addr_o, 32'h2);
        pop_one();
        check("c_count2", count_o, 1);
        check("c_valid2", instr_valid_o, 1'b1);
        check("c_instr2", {16'h0, instr_o[15:0]}, 32'h0000);
        check("c_c2", instr_compressed_o, 1'b1);
        check("c_pc2", instr_addr_o, 32'h6);
        pop_one();
        check("c_valid_end", instr_valid_o, 1'b0);
        check("c_pc_end", instr_addr_o, 32'h8);

        // Fill to capacity, then pop under a held fetch_valid_i
        do_clear(32'h0);
        push_word(32'h0010_0093);
        push_word(32'h0020_0113);
        push_word(32'h0030_0193);
        push_word(32'h0040_0213);
        check("f_count_full", count_o, 8);
        check("f_ready_full", fetch_ready_o, 1'b0);
        check("f_instr_full", instr_o, 32'h0010_0093);
        fetch_valid_i = 1'b1; fetch_data_i = 32'h0050_0293; instr_ready_i = 1'b1;
        step();
        check("f_count_pop", count_o, 6);
        check("f_ready_pop", fetch_ready_o, 1'b1);
        check("f_instr_pop", instr_o, 32'h0020_0113);
        step();
        check("f_count_pushpop", count_o, 6);
        check("f_instr_pushpop", instr_o, 32'h0030_0193);
        fetch_data_i = 32'h0060_0313; instr_ready_i = 1'b0;
        step();
        check("f_count_refill", count_o, 8);
        check("f_ready_refill", fetch_ready_o, 1'b0);

        // Clear wins over a simultaneous push and pop
        fetch_valid_i = 1'b1; instr_ready_i = 1'b1;
        clear_i = 1'b1; clear_addr_i = 32'h40;
        step();
        clear_i = 1'b0; fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
        #1;
        check("clr_count", count_o, 0);
        check("clr_valid", instr_valid_o, 1'b0);
        check("clr_pc", instr_addr_o, 32'h40);

        // Continuous stream across three pointer wraps with backpressure
        do_clear(32'h2);
        wi = 0;
        ii = 0;
        for (int cyc = 0; cyc < 300 && ii < 16; cyc++) begin
            fetch_valid_i = (wi < 13);
            if (wi < 13) fetch_data_i = stream_w[wi];
            instr_ready_i = (cyc % 3) != 2;
            #1;
            push_ok = fetch_valid_i && fetch_ready_o;
            pop_ok  = instr_valid_o && instr_ready_i;
            if (pop_ok) begin
                check($sformatf("w_instr%0d", ii),
                      exp_c[ii] ? {16'h0, instr_o[15:0]} : instr_o, exp_instr[ii]);
                check($sformatf("w_pc%0d", ii), instr_addr_o, exp_pc[ii]);
                check($sformatf("w_c%0d", ii), instr_compressed_o, exp_c[ii]);
            end
            @(posedge clk);
            #1;
            if (push_ok) wi++;
            if (pop_ok) ii++;
        end
        fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
        check("w_done", ii, 16);

        // Asynchronous reset mid-stream
        do_clear(32'h0);
        push_word(32'h0013_0093);
        push_word(32'h0000_0013);
        check("r_valid_pre", instr_valid_o, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("r_valid", instr_valid_o, 1'b0);
        check("r_ready", fetch_ready_o, 1'b1);
        check("r_addr", instr_addr_o, 32'h0);
        check("r_count", count_o, 0);
        #2 rst_n = 1'b1;
        step();

        // Latency from an empty buffer
        fetch_valid_i = 1'b1; fetch_data_i = 32'h0000_0013;
`ifdef FETCH_REALIGN_BYPASS_EN
        instr_ready_i = 1'b1;
        #1;
        check("bp_valid", instr_valid_o, 1'b1);
        check("bp_instr", instr_o, 32'h0000_0013);
        step();
        fetch_valid_i = 1'b0; instr_ready_i = 1'b0;
        #1;
        check("bp_count", count_o, 0);
        check("bp_pc", instr_addr_o, 32'h4);
`else
        instr_ready_i = 1'b0;
        #1;
        check("lat_valid0", instr_valid_o, 1'b0);
        step();
        fetch_valid_i = 1'b0;
        #1;
        check("lat_valid1", instr_valid_o, 1'b1);
        check("lat_count", count_o, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
